// File: rtl/queue_pkg.sv
// Shared sizing and pointer helpers for the multi-channel circular FIFO.
package queue_pkg;

  function automatic int ptr_w(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/queue_fifo_mem.sv
// Register-array storage: one write port, one registered read port.
module queue_fifo_mem
  import queue_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 3,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/queue_fifo_mc.sv
// Multi-channel circular FIFO with count, flags and almost-full.
// Optional sticky error flags under QUEUE_FIFO_ERR_EN.
module queue_fifo_mc
  import queue_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter int CHANNELS = 1,
  parameter int AF_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [WIDTH*CHANNELS-1:0]   din,
  input  logic                        rd_en,
  output logic [WIDTH*CHANNELS-1:0]   dout,
  output logic                        dout_vld,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        ovf_err,
  output logic                        udf_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int DW = WIDTH * CHANNELS;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dout_vld_q, dout_vld_d;
  logic          push, pop;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign in_rdy      = !full;
  assign count       = count_q;
  assign dout_vld    = dout_vld_q;

  always_comb begin
    push       = in_vld && !full;
    pop        = rd_en && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dout_vld_d = pop;
    if (push) begin
      wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  queue_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push && !rst),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (pop && !rst),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

`ifdef QUEUE_FIFO_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  always_comb begin
    ovf_err_d = ovf_err_q || (in_vld && full);
    udf_err_d = udf_err_q || (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
  assign udf_err = udf_err_q;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule
